// File: rtl/harmonic_scaler_pkg.sv
// Shared types and constants for the multi-channel harmonic scaler.
package harmonic_scaler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    COMB = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic MODE_LINEAR    = 1'b0;
  localparam logic MODE_GEOMETRIC = 1'b1;

endpackage

// File: rtl/harmonic_scaler_scale_step.sv
// Single-channel decay step: linear subtract or geometric (mult*scale)>>DIV_BIT,
// with a minimum decrement of 1 in geometric mode and saturation at zero.
module scale_step
  import harmonic_scaler_pkg::*;
#(
  parameter int DIV_BIT = 9
) (
  input  logic [DIV_BIT-1:0] i_mult,
  input  logic [DIV_BIT-1:0] i_scale,
  input  logic               i_mode,
  output logic [DIV_BIT-1:0] o_next
);

  logic [2*DIV_BIT-1:0] prod;
  logic [DIV_BIT-1:0]   dec;

  always_comb begin
    prod = {{DIV_BIT{1'b0}}, i_mult} * {{DIV_BIT{1'b0}}, i_scale};
    dec  = i_scale;
    if (i_mode == MODE_GEOMETRIC) begin
      dec = prod[2*DIV_BIT-1:DIV_BIT];
      // Keep small non-zero multiples decaying instead of stalling forever.
      if ((dec == '0) && (i_mult != '0) && (i_scale != '0)) begin
        dec = DIV_BIT'(1);
      end
    end
    o_next = (i_mult >= dec) ? (i_mult - dec) : '0;
  end

endmodule

// File: rtl/harmonic_scaler.sv
// Multi-channel harmonic amplitude scaler: one shared decay unit walks the
// channels, then the comb/parity mute and harmonic index are updated.
module harmonic_scaler
  import harmonic_scaler_pkg::*;
#(
  parameter int DIV_BIT   = 9,
  parameter int CHANNELS  = 2,
  parameter int COMB_BITS = 8
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset_n,
  input  logic                        i_Restart,
  input  logic                        i_Start,
  input  logic                        i_Mode,
  input  logic                        i_Odd_Only,
  input  logic [CHANNELS*DIV_BIT-1:0] i_Scale,
  input  logic [CHANNELS*DIV_BIT-1:0] i_Initial,
  input  logic [COMB_BITS-1:0]        i_Comb_Interval,
  output logic [CHANNELS*DIV_BIT-1:0] o_Mult,
  output logic                        o_Muted,
  output logic [7:0]                  o_Harmonic,
  output logic                        o_Exhausted,
  output logic                        o_Mult_Ready
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_e               state_q, state_d;
  logic [DIV_BIT-1:0]   mult_q [CHANNELS];
  logic [DIV_BIT-1:0]   mult_d [CHANNELS];
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [COMB_BITS-1:0] comb_cnt_q, comb_cnt_d;
  logic                 comb_mute_q, comb_mute_d;
  logic [7:0]           harmonic_q, harmonic_d;
  logic                 muted_q, muted_d;
  logic                 exhausted_q, exhausted_d;
  logic                 ready_q, ready_d;

  logic [DIV_BIT-1:0]   cur_mult, cur_scale, next_mult;
  logic                 mult_zero;

  always_comb begin
    cur_mult  = mult_q[idx_q];
    cur_scale = i_Scale[int'(idx_q)*DIV_BIT +: DIV_BIT];
  end

  scale_step #(.DIV_BIT(DIV_BIT)) u_scale_step (
    .i_mult  (cur_mult),
    .i_scale (cur_scale),
    .i_mode  (i_Mode),
    .o_next  (next_mult)
  );

  always_comb begin
    mult_zero = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      if (mult_q[c] != '0) mult_zero = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    mult_d      = mult_q;
    idx_d       = idx_q;
    comb_cnt_d  = comb_cnt_q;
    comb_mute_d = comb_mute_q;
    harmonic_d  = harmonic_q;
    muted_d     = muted_q;
    exhausted_d = exhausted_q;
    ready_d     = ready_q;
    if (i_Restart) begin
      for (int c = 0; c < CHANNELS; c++) begin
        mult_d[c] = i_Initial[c*DIV_BIT +: DIV_BIT];
      end
      harmonic_d  = 8'd1;
      comb_cnt_d  = '0;
      comb_mute_d = 1'b0;
      muted_d     = 1'b0;
      ready_d     = 1'b1;
      exhausted_d = (i_Initial == '0);
      state_d     = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_Start && ready_q) begin
            ready_d = 1'b0;
            muted_d = 1'b0;
            idx_d   = '0;
            state_d = CALC;
          end
        end
        CALC: begin
          mult_d[idx_q] = next_mult;
          if (idx_q == IDX_W'(CHANNELS-1)) state_d = COMB;
          else                             idx_d   = idx_q + 1'b1;
        end
        COMB: begin
          harmonic_d = (harmonic_q == 8'd255) ? harmonic_q : harmonic_q + 8'd1;
          if (i_Comb_Interval == '0) begin
            comb_cnt_d  = '0;
            comb_mute_d = 1'b0;
          end else if (comb_cnt_q == i_Comb_Interval) begin
            comb_cnt_d  = '0;
            comb_mute_d = 1'b1;
          end else begin
            comb_cnt_d  = comb_cnt_q + 1'b1;
            comb_mute_d = 1'b0;
          end
          state_d = DONE;
        end
        DONE: begin
          // harmonic_q already holds the new index here.
          muted_d     = comb_mute_q | (i_Odd_Only & ~harmonic_q[0]);
          exhausted_d = mult_zero;
          ready_d     = 1'b1;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q     <= IDLE;
      for (int c = 0; c < CHANNELS; c++) mult_q[c] <= '0;
      idx_q       <= '0;
      comb_cnt_q  <= '0;
      comb_mute_q <= 1'b0;
      harmonic_q  <= 8'd0;
      muted_q     <= 1'b0;
      exhausted_q <= 1'b1;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      mult_q      <= mult_d;
      idx_q       <= idx_d;
      comb_cnt_q  <= comb_cnt_d;
      comb_mute_q <= comb_mute_d;
      harmonic_q  <= harmonic_d;
      muted_q     <= muted_d;
      exhausted_q <= exhausted_d;
      ready_q     <= ready_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign o_Mult[g*DIV_BIT +: DIV_BIT] = mult_q[g];
  end

  assign o_Muted      = muted_q;
  assign o_Harmonic   = harmonic_q;
  assign o_Exhausted  = exhausted_q;
  assign o_Mult_Ready = ready_q;

endmodule

// File: tb/tb_harmonic_scaler.sv
// Directed self-checking bench for harmonic_scaler (DIV_BIT=9, CHANNELS=2).
module tb_harmonic_scaler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        restart, start, mode, odd;
  logic [17:0] scale, init;
  logic [7:0]  interval;
  logic [17:0] mult;
  logic        muted, exh, rdy;
  logic [7:0]  harm;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  harmonic_scaler #(.DIV_BIT(9), .CHANNELS(2), .COMB_BITS(8)) dut (
    .i_Clock         (clk),
    .i_Reset_n       (rst_n),
    .i_Restart       (restart),
    .i_Start         (start),
    .i_Mode          (mode),
    .i_Odd_Only      (odd),
    .i_Scale         (scale),
    .i_Initial       (init),
    .i_Comb_Interval (interval),
    .o_Mult          (mult),
    .o_Muted         (muted),
    .o_Harmonic      (harm),
    .o_Exhausted     (exh),
    .o_Mult_Ready    (rdy)
  );

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  task automatic do_step(output int busy);
    int w;
    w = 0;
    while (rdy !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy = 0;
    while (rdy !== 1'b1 && busy < 50) begin @(posedge clk); #1; busy++; end
    if (busy >= 50) begin
      checks++; errors++;
      $display("FAIL step_timeout: ready=%b after %0d cycles, required 1", rdy, busy);
    end
  endtask

  task automatic test_reset();
    mode = 1'b0; odd = 1'b0; interval = 8'd0;
    init = {9'd300, 9'd100}; scale = {9'd50, 9'd40};
    do_restart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_busy_before: ready=%b required 0", rdy); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (mult !== 18'd0) begin errors++; $display("FAIL reset_mult: got %h required 0", mult); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", rdy); end
    checks++; if (muted !== 1'b0) begin errors++; $display("FAIL reset_muted: got %b required 0", muted); end
    checks++; if (harm !== 8'd0) begin errors++; $display("FAIL reset_harmonic: got %0d required 0", harm); end
    checks++; if (exh !== 1'b1) begin errors++; $display("FAIL reset_exhausted: got %b required 1", exh); end
  endtask

  task automatic test_linear();
    logic [17:0] exp_m [3];
    int busy;
    exp_m[0] = {9'd250, 9'd60};
    exp_m[1] = {9'd200, 9'd20};
    exp_m[2] = {9'd150, 9'd0};
    mode = 1'b0; odd = 1'b0; interval = 8'd0;
    init = {9'd300, 9'd100}; scale = {9'd50, 9'd40};
    do_restart();
    for (int i = 0; i < 3; i++) begin
      do_step(busy);
      checks++; if (mult !== exp_m[i]) begin errors++;
        $display("FAIL linear_mult[%0d]: got %0d/%0d required %0d/%0d", i, mult[17:9], mult[8:0], exp_m[i][17:9], exp_m[i][8:0]); end
      checks++; if (busy != 4) begin errors++; $display("FAIL linear_busy[%0d]: got %0d required 4", i, busy); end
      checks++; if (exh !== 1'b0) begin errors++; $display("FAIL linear_exhausted[%0d]: got %b required 0", i, exh); end
    end
  endtask

  task automatic test_geometric();
    int busy;
    int exp_v [9] = '{128, 64, 32, 16, 8, 4, 2, 1, 0};
    logic [17:0] e;
    mode = 1'b1; odd = 1'b0; interval = 8'd0;
    init = {9'd256, 9'd256}; scale = {9'd256, 9'd256};
    do_restart();
    for (int i = 0; i < 9; i++) begin
      do_step(busy);
      e = {9'(exp_v[i]), 9'(exp_v[i])};
      checks++; if (mult !== e) begin errors++;
        $display("FAIL geo_mult[%0d]: got %0d/%0d required %0d", i, mult[17:9], mult[8:0], exp_v[i]); end
      checks++; if (exh !== (exp_v[i] == 0)) begin errors++;
        $display("FAIL geo_exhausted[%0d]: got %b required %b", i, exh, exp_v[i] == 0); end
    end
    init = {9'd256, 9'd10}; scale = {9'd1, 9'd0};
    do_restart();
    do_step(busy);
    checks++; if (mult !== {9'd255, 9'd10}) begin errors++;
      $display("FAIL geo_min1: got %0d/%0d required 255/10", mult[17:9], mult[8:0]); end
  endtask

  task automatic test_comb();
    int busy;
    logic exp_mu [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    mode = 1'b0; odd = 1'b0; scale = 18'd0; init = {9'd5, 9'd5};
    interval = 8'd2;
    do_restart();
    for (int i = 0; i < 6; i++) begin
      do_step(busy);
      checks++; if (muted !== exp_mu[i]) begin errors++;
        $display("FAIL comb2_muted[%0d]: got %b required %b", i, muted, exp_mu[i]); end
    end
    interval = 8'd0;
    do_restart();
    for (int i = 0; i < 6; i++) begin
      do_step(busy);
      checks++; if (muted !== 1'b0) begin errors++;
        $display("FAIL comb0_muted[%0d]: got %b required 0", i, muted); end
    end
  endtask

  task automatic test_odd_only();
    int busy;
    logic [7:0] exp_h [3] = '{8'd2, 8'd3, 8'd4};
    logic       exp_mu [3] = '{1'b1, 1'b0, 1'b1};
    mode = 1'b0; odd = 1'b1; interval = 8'd0; scale = 18'd0; init = {9'd7, 9'd7};
    do_restart();
    for (int i = 0; i < 3; i++) begin
      do_step(busy);
      checks++; if (harm !== exp_h[i]) begin errors++;
        $display("FAIL odd_harmonic[%0d]: got %0d required %0d", i, harm, exp_h[i]); end
      checks++; if (muted !== exp_mu[i]) begin errors++;
        $display("FAIL odd_muted[%0d]: got %b required %b", i, muted, exp_mu[i]); end
    end
    for (int i = 0; i < 260; i++) do_step(busy);
    checks++; if (harm !== 8'd255) begin errors++; $display("FAIL harmonic_saturate: got %0d required 255", harm); end
    checks++; if (muted !== 1'b0) begin errors++; $display("FAIL harmonic_255_muted: got %b required 0", muted); end
    odd = 1'b0;
  endtask

  task automatic test_restart();
    int busy;
    mode = 1'b0; odd = 1'b0; interval = 8'd0;
    init = {9'd300, 9'd100}; scale = {9'd50, 9'd40};
    // Restart during the second CALC cycle.
    do_restart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checks++; if (mult !== {9'd300, 9'd60}) begin errors++;
      $display("FAIL mid_ch0_update: got %0d/%0d required 300/60", mult[17:9], mult[8:0]); end
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL mid_restart_ready: got %b required 1", rdy); end
    checks++; if (mult !== init) begin errors++;
      $display("FAIL mid_restart_mult: got %0d/%0d required 300/100", mult[17:9], mult[8:0]); end
    repeat (6) @(posedge clk); #1;
    checks++; if (mult !== init) begin errors++;
      $display("FAIL mid_restart_hold: got %0d/%0d required 300/100", mult[17:9], mult[8:0]); end
    checks++; if (harm !== 8'd1) begin errors++; $display("FAIL mid_restart_harmonic: got %0d required 1", harm); end
    // Restart and start together.
    do_step(busy);
    restart = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0; start = 1'b0;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rs_ready: got %b required 1", rdy); end
    checks++; if (harm !== 8'd1) begin errors++; $display("FAIL rs_harmonic: got %0d required 1", harm); end
    repeat (5) @(posedge clk); #1;
    checks++; if (mult !== init) begin errors++;
      $display("FAIL rs_mult: got %0d/%0d required 300/100", mult[17:9], mult[8:0]); end
  endtask

  task automatic test_busy_start();
    int w;
    mode = 1'b0; odd = 1'b0; interval = 8'd0;
    init = {9'd300, 9'd100}; scale = {9'd50, 9'd40};
    do_restart();
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    w = 0;
    while (rdy !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL busy_timeout: ready=%b required 1", rdy); end
    repeat (6) @(posedge clk); #1;
    checks++; if (mult !== {9'd250, 9'd60}) begin errors++;
      $display("FAIL busy_start_mult: got %0d/%0d required 250/60", mult[17:9], mult[8:0]); end
    checks++; if (harm !== 8'd2) begin errors++; $display("FAIL busy_start_harmonic: got %0d required 2", harm); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL busy_start_ready: got %b required 1", rdy); end
  endtask

  initial begin
    rst_n = 1'b0; restart = 1'b0; start = 1'b0; mode = 1'b0; odd = 1'b0;
    scale = '0; init = '0; interval = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_linear();
    test_geometric();
    test_comb();
    test_odd_only();
    test_restart();
    test_busy_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
